// File: rtl/countdown_timer16_pkg.sv
// countdown_timer16_pkg: shared state encoding and default width for the countdown timer
package countdown_timer16_pkg;
  localparam int DEFAULT_WIDTH = 16;
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_EXPIRED = 2'd2
  } timerState_t;
endpackage

// File: rtl/countdown_timer16_if.sv
// countdown_timer16_if: CPU-facing control/status bundle of the countdown timer
interface countdown_timer16_if import countdown_timer16_pkg::*; #(parameter int WIDTH = DEFAULT_WIDTH);
  logic [WIDTH-1:0] in;
  logic [WIDTH-1:0] out;
  logic load;
  logic start;
  logic pause;
  logic busy;
  logic done;
  logic zero;
  modport master(output in, load, start, pause, input out, busy, done, zero);
  modport slave(input in, load, start, pause, output out, busy, done, zero);
endinterface

// File: rtl/countdown_timer16_decrementor16.sv
// decrementor16: combinational modulo-2^WIDTH decrement, mirror of the incrementor
module decrementor16 #(parameter int WIDTH = 16) (
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out
);
  assign out = in - WIDTH'(1);
endmodule

// File: rtl/countdown_timer16.sv
// countdown_timer16: loadable down-counter with start/pause, expiry pulse and optional auto-reload
module countdown_timer16 import countdown_timer16_pkg::*; #(
  parameter int WIDTH       = DEFAULT_WIDTH,
  parameter bit AUTO_RELOAD = 1'b0
) (
  input logic clk,
  input logic reset,
  countdown_timer16_if.slave bus
);
  timerState_t state;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] reloadQ;
  logic [WIDTH-1:0] decOut;
  logic done;
  logic expiring;
  logic reloading;
  decrementor16 #(.WIDTH(WIDTH)) uDec (.in(count), .out(decOut));
  // count of 0 cannot occur in RUN, but treating it as expiry keeps the wrap unreachable
  assign expiring  = count <= WIDTH'(1);
  assign reloading = AUTO_RELOAD && (reloadQ != '0);
  // state, count, reload value and expiry pulse; load beats start beats pause beats decrement
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      count   <= '0;
      reloadQ <= '0;
      done    <= 1'b0;
    end else if (bus.load) begin
      state   <= ST_IDLE;
      count   <= bus.in;
      reloadQ <= bus.in;
      done    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done  <= bus.start && (count == '0);
          state <= !bus.start ? ST_IDLE : (count != '0) ? ST_RUN : ST_EXPIRED;
        end
        ST_RUN: begin
          if (!bus.pause) begin
            done  <= expiring;
            count <= !expiring ? decOut : reloading ? reloadQ : '0;
            state <= (expiring && !reloading) ? ST_EXPIRED : ST_RUN;
          end
        end
        default: begin
          done  <= 1'b0;
          count <= '0;
          state <= ST_EXPIRED;
        end
      endcase
    end
  end
  assign bus.out  = count;
  assign bus.busy = state == ST_RUN;
  assign bus.done = done;
  assign bus.zero = count == '0;
endmodule
